regfile_writeback_queue: RTL and testbench
==========================================

Name: regfile_writeback_queue

Overview:
- Write-side producer for the register file: buffers register-write results from execute/memory/multi-cycle units and drains one per cycle onto the regfile's single write port (W_addr/W_data/wr_enable).
- Also answers two read-side queries (A/B) with the youngest pending value, so operand reads see writes not yet committed.
- Sits between pipeline result buses and the regfile write port.

Parameters:
width, 32, data width of a register value
DEPTH, 4, queue entries; power of 2, >= 2

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
in_valid  input  1  producer offers a write
in_ready  output  1  queue can accept this cycle
in_addr  input  5  destination register
in_data  input  width  value to write
wb_stall  input  1  hold drain this cycle (regfile port borrowed/frozen)
W_addr  output  5  regfile write address
W_data  output  width  regfile write data
wr_enable  output  1  regfile write strobe
A_addr  input  5  query address A
B_addr  input  5  query address B
A_hit  output  1  pending write to A_addr exists
A_fwd_data  output  width  youngest pending value for A_addr
B_hit  output  1  as A, for B_addr
B_fwd_data  output  width  as A, for B_addr
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: circular buffer of DEPTH {addr[4:0], data[width-1:0]} entries; head/tail pointers wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
- Reset (reset=1 at posedge): head=tail=0, count=0; entry contents don't-care. After reset: in_ready=1, wr_enable=0, A_hit=B_hit=0, fwd data=0.
- in_ready = (count != DEPTH); purely from registered state, no combinational path from in_valid or wb_stall.
- Enqueue: in_valid && in_ready at posedge -> entry written at tail, tail++.
- in_addr==0: handshake completes (in_ready honoured) but nothing stored; count unchanged. r0 is never written.
- Drain: wr_enable = (count != 0) && !wb_stall. W_addr/W_data = head entry (combinational from registered storage). When wr_enable=1 the regfile consumes at the posedge, head++.
- Latency without bypass: entry accepted at edge N appears on W port in cycle N+1 at the earliest.
- Simultaneous enqueue and drain: count unchanged, both pointers advance. Full + drain: in_ready still 0 that cycle (no same-cycle refill).
- Order: strict FIFO; two writes to the same register commit in acceptance order.
- Forwarding: X_hit=1 iff X_addr!=0 and some valid entry has addr==X_addr. X_fwd_data = data of the youngest such entry (closest to tail). If no hit, X_fwd_data=0. Incoming in_* is not searched. The head entry being drained this cycle still counts as a hit.
- wb_stall held indefinitely: queue fills to DEPTH, in_ready=0, contents and hits stable.
- reset asserted mid-operation: all pending writes discarded; no wr_enable in the reset cycle or the cycle after.

Optional Feature:
- Macro WBQ_BYPASS_EN.
- Defined: when count==0, !wb_stall, in_valid=1 and in_addr!=0, the incoming write drives W_addr/W_data with wr_enable=1 combinationally in the same cycle and is not stored. In that case in_ready=1, count stays 0, and queries are unaffected (no hit from the bypassed write).
- Not defined: minimum latency is 1 cycle, as above; no combinational in_* -> W_* path.

Test Plan:
- Reset then in_valid=1 addr=5 data=0xDEADBEEF one cycle, wb_stall=0 -> next cycle wr_enable=1, W_addr=5, W_data=0xDEADBEEF; following cycle wr_enable=0, count=0.
- wb_stall=1; enqueue addr 1..5 data 0x11..0x55 -> count reaches 4, in_ready=0, fifth write not accepted. Release stall -> writes 1,2,3,4 drain on consecutive cycles; in_ready=1 one cycle after the first drain.
- Stall; enqueue addr 7 data 0xA then addr 7 data 0xB; A_addr=7 -> A_hit=1, A_fwd_data=0xB. B_addr=8 -> B_hit=0, B_fwd_data=0. Release -> commits 0xA then 0xB.
- Enqueue in_addr=0 data 0x1234 -> in_ready=1, count stays 0, no wr_enable. A_addr=0 -> A_hit=0 throughout.
- Stall with 3 entries, then assert reset one cycle -> count=0, in_ready=1, no wr_enable in the reset cycle or the next; hits=0.
- WBQ_BYPASS_EN defined, empty queue, addr=9 data=0x77 -> wr_enable=1, W_addr=9, W_data=0x77 in the same cycle, count stays 0. Undefined -> same stimulus commits one cycle later.

Source files
------------

// File: rtl/regfile_writeback_queue.sv
// Regfile write-side queue: buffers results, drains one per cycle, forwards youngest pending value to A/B queries.
// Latency: 1 cycle accept-to-commit; 0 cycles on an empty queue when WBQ_BYPASS_EN is defined.
// Backpressure: in_ready drops only when full (registered); wb_stall holds the drain and contents.
module regfile_writeback_queue #(
  parameter int width = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_addr,
  input  logic [width-1:0]         in_data,
  input  logic                     wb_stall,
  output logic [4:0]               W_addr,
  output logic [width-1:0]         W_data,
  output logic                     wr_enable,
  input  logic [4:0]               A_addr,
  input  logic [4:0]               B_addr,
  output logic                     A_hit,
  output logic [width-1:0]         A_fwd_data,
  output logic                     B_hit,
  output logic [width-1:0]         B_fwd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [4:0]       addr;
    logic [width-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   cnt_q;
  logic          bypass;
  logic          drain;
  logic          enq;

`ifdef WBQ_BYPASS_EN
  // An empty, unstalled queue hands a live write straight to the regfile port.
  assign bypass = !reset && (cnt_q == '0) && !wb_stall && in_valid && (in_addr != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  assign in_ready  = (cnt_q != FULL);
  // Reset gates the strobe so a discarded entry never reaches the regfile.
  assign drain     = !reset && (cnt_q != '0) && !wb_stall;
  assign enq       = !reset && in_valid && in_ready && (in_addr != 5'd0) && !bypass;
  assign wr_enable = drain || bypass;
  assign W_addr    = bypass ? in_addr : mem[head].addr;
  assign W_data    = bypass ? in_data : mem[head].data;
  assign count     = cnt_q;

  always_ff @(posedge clk) begin
    if (enq) begin
      mem[tail] <= '{addr: in_addr, data: in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
    end else begin
      if (enq) begin
        tail <= tail + PW'(1);
      end
      if (drain) begin
        head <= head + PW'(1);
      end
      if (enq && !drain) begin
        cnt_q <= cnt_q + (PW+1)'(1);
      end else if (drain && !enq) begin
        cnt_q <= cnt_q - (PW+1)'(1);
      end
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest pending write.
  always_comb begin
    A_hit      = 1'b0;
    A_fwd_data = '0;
    B_hit      = 1'b0;
    B_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((PW+1)'(i) < cnt_q) begin
        if ((A_addr != 5'd0) && (mem[head + PW'(i)].addr == A_addr)) begin
          A_hit      = 1'b1;
          A_fwd_data = mem[head + PW'(i)].data;
        end
        if ((B_addr != 5'd0) && (mem[head + PW'(i)].addr == B_addr)) begin
          B_hit      = 1'b1;
          B_fwd_data = mem[head + PW'(i)].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: directed literal checks plus randomized traffic against a queue model.
module tb_regfile_writeback_queue;
  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   in_addr = '0;
  logic [W-1:0] in_data = '0;
  logic         wb_stall = 1'b0;
  logic [4:0]   W_addr;
  logic [W-1:0] W_data;
  logic         wr_enable;
  logic [4:0]   A_addr = '0;
  logic [4:0]   B_addr = '0;
  logic         A_hit;
  logic [W-1:0] A_fwd_data;
  logic         B_hit;
  logic [W-1:0] B_fwd_data;
  logic [2:0]   count;

  regfile_writeback_queue #(.width(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .wb_stall(wb_stall),
    .W_addr(W_addr), .W_data(W_data), .wr_enable(wr_enable),
    .A_addr(A_addr), .B_addr(B_addr), .A_hit(A_hit), .A_fwd_data(A_fwd_data),
    .B_hit(B_hit), .B_fwd_data(B_fwd_data), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]   addr;
    logic [W-1:0] data;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_bypass();
`ifdef WBQ_BYPASS_EN
    return !reset && (q.size() == 0) && !wb_stall && in_valid && (in_addr != 5'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void lookup(input logic [4:0] a, output bit hit, output logic [W-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].addr == a) begin
          hit = 1'b1;
          d   = q[i].data;
          break;
        end
      end
    end
  endfunction

  // Model state advances on the same edge the DUT does.
  always @(posedge clk) begin
    bit byp, rdy, wr;
    if (reset) begin
      q.delete();
    end else begin
      byp = model_bypass();
      rdy = (q.size() != DEPTH);
      wr  = ((q.size() != 0) && !wb_stall) || byp;
      if (wr && !byp) void'(q.pop_front());
      if (in_valid && rdy && (in_addr != 5'd0) && !byp) q.push_back({in_addr, in_data});
    end
  end

  always @(negedge clk) begin
    bit byp, exp_wr, ah, bh;
    logic [W-1:0] ad, bd;
    if (mon_en) begin
      byp    = model_bypass();
      exp_wr = !reset && (((q.size() != 0) && !wb_stall) || byp);
      chk("m_in_ready", in_ready, (q.size() != DEPTH));
      chk("m_wr_enable", wr_enable, exp_wr);
      chk("m_count", count, q.size());
      if (exp_wr) begin
        chk("m_W_addr", W_addr, byp ? in_addr : q[0].addr);
        chk("m_W_data", W_data, byp ? in_data : q[0].data);
      end
      lookup(A_addr, ah, ad);
      lookup(B_addr, bh, bd);
      chk("m_A_hit", A_hit, ah);
      chk("m_A_fwd", A_fwd_data, ad);
      chk("m_B_hit", B_hit, bh);
      chk("m_B_fwd", B_fwd_data, bd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [4:0] a, input logic [W-1:0] d, input bit st);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    wb_stall = st;
  endtask

  initial begin
    int stall_pct;
    // Reset state
    drive(0, 0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wr_enable", wr_enable, 0);
    chk("rst_count", count, 0);
    chk("rst_A_hit", A_hit, 0);
    chk("rst_B_hit", B_hit, 0);
    chk("rst_A_fwd", A_fwd_data, 0);
    tick();

    // Single write, minimum latency
    drive(1, 5, 32'hDEADBEEF, 0);
    @(negedge clk);
`ifdef WBQ_BYPASS_EN
    chk("t1_byp_wr", wr_enable, 1);
    chk("t1_byp_addr", W_addr, 5);
    chk("t1_byp_data", W_data, 32'hDEADBEEF);
`endif
    tick();
    drive(0, 0, 0, 0);
    @(negedge clk);
`ifndef WBQ_BYPASS_EN
    chk("t1_wr", wr_enable, 1);
    chk("t1_addr", W_addr, 5);
    chk("t1_data", W_data, 32'hDEADBEEF);
    tick();
    @(negedge clk);
`endif
    chk("t1_idle_wr", wr_enable, 0);
    chk("t1_idle_count", count, 0);
    tick();

    // Fill under stall, then drain in order
    for (int i = 1; i <= 5; i++) begin
      drive(1, 5'(i), W'(i * 'h11), 1);
      tick();
    end
    drive(0, 0, 0, 1);
    @(negedge clk);
    chk("t2_count_full", count, 4);
    chk("t2_in_ready_full", in_ready, 0);
    tick();
    drive(0, 0, 0, 0);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk("t2_drain_wr", wr_enable, 1);
      chk("t2_drain_addr", W_addr, 5'(j));
      chk("t2_drain_data", W_data, W'(j * 'h11));
      if (j == 1) chk("t2_ready_full_drain", in_ready, 0);
      if (j == 2) chk("t2_ready_after", in_ready, 1);
      tick();
    end
    @(negedge clk);
    chk("t2_empty_wr", wr_enable, 0);
    tick();

    // Same register twice: youngest forwarded, both committed in order
    A_addr = 7;
    B_addr = 8;
    drive(1, 7, 32'hA, 1);
    tick();
    drive(1, 7, 32'hB, 1);
    tick();
    drive(0, 0, 0, 1);
    @(negedge clk);
    chk("t3_A_hit", A_hit, 1);
    chk("t3_A_fwd", A_fwd_data, 32'hB);
    chk("t3_B_hit", B_hit, 0);
    chk("t3_B_fwd", B_fwd_data, 0);
    tick();
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("t3_first", W_data, 32'hA);
    tick();
    @(negedge clk);
    chk("t3_second", W_data, 32'hB);
    chk("t3_head_hit", A_hit, 1);
    tick();
    @(negedge clk);
    chk("t3_done_hit", A_hit, 0);
    tick();

    // r0 writes are swallowed
    A_addr = 0;
    drive(1, 0, 32'h1234, 0);
    @(negedge clk);
    chk("t4_ready", in_ready, 1);
    chk("t4_wr", wr_enable, 0);
    tick();
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("t4_count", count, 0);
    chk("t4_wr_after", wr_enable, 0);
    chk("t4_A_hit", A_hit, 0);
    tick();

    // Reset with pending entries
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(3 + i), W'(32'h100 + i), 1);
      tick();
    end
    A_addr = 4;
    drive(0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_wr_in_reset", wr_enable, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_wr_after", wr_enable, 0);
    chk("t5_count", count, 0);
    chk("t5_ready", in_ready, 1);
    chk("t5_A_hit", A_hit, 0);
    tick();

    // Empty-queue write: same cycle with bypass, next cycle without
    A_addr = 9;
    drive(1, 9, 32'h77, 0);
    @(negedge clk);
`ifdef WBQ_BYPASS_EN
    chk("t6_wr", wr_enable, 1);
    chk("t6_addr", W_addr, 9);
    chk("t6_data", W_data, 32'h77);
    chk("t6_count", count, 0);
    chk("t6_no_hit", A_hit, 0);
`else
    chk("t6_wr_none", wr_enable, 0);
`endif
    tick();
    drive(0, 0, 0, 0);
    @(negedge clk);
`ifdef WBQ_BYPASS_EN
    chk("t6_after_wr", wr_enable, 0);
    chk("t6_after_count", count, 0);
`else
    chk("t6_late_wr", wr_enable, 1);
    chk("t6_late_addr", W_addr, 9);
    chk("t6_late_data", W_data, 32'h77);
`endif
    tick();

    // Randomized traffic checked by the model
    stall_pct = 10;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) begin
        case ($urandom_range(0, 2))
          0: stall_pct = 10;
          1: stall_pct = 60;
          default: stall_pct = 95;
        endcase
      end
      reset    = ($urandom_range(0, 199) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_addr  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      in_data  = $urandom;
      wb_stall = ($urandom_range(0, 99) < stall_pct);
      A_addr   = 5'($urandom_range(0, 7));
      B_addr   = 5'($urandom_range(0, 7));
      tick();
    end
    reset  = 1'b0;
    mon_en = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
